systolic_mm_array: RTL and testbench

- Output-stationary N×N systolic array of multiply-accumulate processing elements (PEs) that computes C = A·B for N×N matrices.
- The upstream driver streams pre-skewed rows of A from the left edge and pre-skewed columns of B from the top edge.
- Each PE holds one element of C in an accumulator.
- All accumulators are exposed continuously on a flat result bus read by the host or test harness.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_pe.sv | 46 ++++
 rtl/systolic_mm_array.sv | 52 +++++
 tb/tb_systolic_mm_array.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, types and result-bus offset helper for the systolic array
package systolic_pkg;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int ACCW = 32;

  typedef logic [DW-1:0]   operand_t;
  typedef logic [ACCW-1:0] acc_t;

  // Bit offset of C[i][j] on the row-major flattened result bus.
  function automatic int res_off(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one MAC processing element with a/b forwarding registers
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; default is unsigned.
module systolic_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [ACCW-1:0] acc
);
  import systolic_pkg::*;

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_ext;

  always_comb begin
    prod     = '0;
    prod_ext = '0;
`ifdef SYSTOLIC_SIGNED_EN
    // Low 2*DW bits of the widened product are exact; then sign-extend.
    prod     = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
    prod_ext = ACCW'($signed(prod));
`else
    prod     = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
    prod_ext = ACCW'(prod);
`endif
  end

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      acc   <= acc + prod_ext;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_mm_array.sv
// rtl/systolic_mm_array.sv - output-stationary NxN systolic matrix multiplier (SYSTOLIC_SIGNED_EN selects signed operands)
module systolic_mm_array #(
  parameter int N    = systolic_pkg::N,
  parameter int DW   = systolic_pkg::DW,
  parameter int ACCW = systolic_pkg::ACCW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*DW-1:0]     a,
  input  logic [N*DW-1:0]     b,
  output logic [N*N*ACCW-1:0] result
);
  import systolic_pkg::*;

  logic [DW-1:0]   a_fwd [N][N];
  logic [DW-1:0]   b_fwd [N][N];
  logic [DW-1:0]   a_src [N][N];
  logic [DW-1:0]   b_src [N][N];
  logic [ACCW-1:0] acc_q [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      // Edge PEs take the external lanes; interior PEs take their neighbour's registered operand.
      if (j == 0) begin : g_a_edge
        assign a_src[i][j] = a[i*DW +: DW];
      end else begin : g_a_int
        assign a_src[i][j] = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src[i][j] = b[j*DW +: DW];
      end else begin : g_b_int
        assign b_src[i][j] = b_fwd[i-1][j];
      end

      systolic_pe #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_src[i][j]),
        .b_in  (b_src[i][j]),
        .a_out (a_fwd[i][j]),
        .b_out (b_fwd[i][j]),
        .acc   (acc_q[i][j])
      );

      assign result[res_off(i, j, N, ACCW) +: ACCW] = acc_q[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// tb/tb_systolic_mm_array.sv - directed self-checking bench for systolic_mm_array
module tb_systolic_mm_array;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int ACCW = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N*DW-1:0]     a;
  logic [N*DW-1:0]     b;
  logic [N*N*ACCW-1:0] result;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  systolic_mm_array #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] elem(input int i, input int j);
    return result[(i*N+j)*ACCW +: ACCW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_step(input int s);
    for (int i = 0; i < N; i++) begin
      int k = s - i;
      a[i*DW +: DW] = (k >= 0 && k < N) ? ma[i][k] : '0;
    end
    for (int j = 0; j < N; j++) begin
      int k = s - j;
      b[j*DW +: DW] = (k >= 0 && k < N) ? mb[k][j] : '0;
    end
  endtask

  task automatic run_steps(input int from, input int upto);
    for (int e = from; e < upto; e++) begin
      drive_step(e);
      tick();
    end
    a = '0;
    b = '0;
  endtask

  task automatic do_reset();
    a = '0;
    b = '0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] va, input logic [DW-1:0] vb);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = va;
        mb[i][j] = vb;
      end
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), elem(i, j), exp);
  endtask

  initial begin
    rst_n = 1'b1;
    a = '0;
    b = '0;

    // Reset with garbage operands on the lanes
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < N; l++) begin
        a[l*DW +: DW] = DW'($urandom);
        b[l*DW +: DW] = DW'($urandom);
      end
      tick();
    end
    check_all("reset", 32'h0);
    rst_n = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check_all("post_reset", 32'h0);

    // Identity times B gives B
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 16'd1 : 16'd0;
        mb[i][j] = DW'(4*i + j + 1);
      end
    run_steps(0, 10);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("ident[%0d][%0d]", i, j), elem(i, j), 32'(4*i + j + 1));

    // All ones: per-element completion timing
    do_reset();
    fill(16'd1, 16'd1);
    run_steps(0, 3);
    check("ones00_e3", elem(0, 0), 32'd3);
    run_steps(3, 4);
    check("ones00_e4", elem(0, 0), 32'd4);
    run_steps(4, 9);
    check("ones33_e9", elem(3, 3), 32'd3);
    run_steps(9, 10);
    check("ones33_e10", elem(3, 3), 32'd4);
    check_all("ones", 32'd4);
    run_steps(10, 13);
    check_all("ones_hold", 32'd4);

`ifdef SYSTOLIC_SIGNED_EN
    // -1 * 2 summed four times
    do_reset();
    fill(16'hFFFF, 16'd2);
    run_steps(0, 10);
    check_all("signed", 32'hFFFF_FFF8);
    // -1 * -1 summed four times
    do_reset();
    fill(16'hFFFF, 16'hFFFF);
    run_steps(0, 10);
    check_all("signed_neg", 32'd4);
`else
    // 0xFFFF^2 * 4 wraps modulo 2^32
    do_reset();
    fill(16'hFFFF, 16'hFFFF);
    run_steps(0, 10);
    check_all("wrap", 32'hFFF8_0004);
`endif

    // Reset mid-stream discards partial sums and in-flight operands
    do_reset();
    fill(16'd1, 16'd1);
    run_steps(0, 3);
    drive_step(3);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    a = '0;
    b = '0;
    check_all("midrst", 32'h0);
    run_steps(0, 10);
    check_all("restream", 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
